// File: rtl/cpu_stat_pkg.sv
// Shared constants and instruction classification for the CPU statistics unit.
// Channel indices, opcode values and the per-cycle event decode.
package cpu_stat_pkg;

    localparam int NUM_CH_MAX = 10;

    localparam int CH_CYCLES  = 0;
    localparam int CH_RETIRED = 1;
    localparam int CH_RTYPE   = 2;
    localparam int CH_JTYPE   = 3;
    localparam int CH_ITYPE   = 4;
    localparam int CH_LOAD    = 5;
    localparam int CH_STORE   = 6;
    localparam int CH_TAKEN   = 7;
    localparam int CH_SYSCALL = 8;
    localparam int CH_EXC     = 9;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    typedef struct packed {
        logic       retire;
        logic       halt;
        logic [5:0] op;
        logic [5:0] funct;
        logic       mem_rd;
        logic       mem_wr;
        logic       br_taken;
        logic       exc;
    } cpu_ev_t;

    // One-hot-per-channel increment mask for this cycle; halt suppresses everything.
    function automatic logic [NUM_CH_MAX-1:0] classify(cpu_ev_t e);
        logic                  rtype;
        logic                  jtype;
        logic [NUM_CH_MAX-1:0] m;
        rtype         = (e.op == OP_RTYPE);
        jtype         = (e.op == OP_J) || (e.op == OP_JAL);
        m             = '0;
        m[CH_CYCLES]  = 1'b1;
        m[CH_RETIRED] = e.retire;
        m[CH_RTYPE]   = e.retire & rtype;
        m[CH_JTYPE]   = e.retire & jtype;
        m[CH_ITYPE]   = e.retire & ~rtype & ~jtype;
        m[CH_LOAD]    = e.retire & e.mem_rd;
        m[CH_STORE]   = e.retire & e.mem_wr;
        m[CH_TAKEN]   = e.retire & e.br_taken;
        m[CH_SYSCALL] = e.retire & rtype & (e.funct == FN_SYSCALL);
        m[CH_EXC]     = e.exc;
        if (e.halt) begin
            m = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/cpu_stat_unit_if.sv
// Readout bus of the statistics unit: request with channel select, registered reply.
interface cpu_stat_unit_if #(
    parameter int CNT_W = 32
);
    logic             rd_req;
    logic [3:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (output rd_req, rd_sel, input rd_data, rd_valid);
    modport slave  (input rd_req, rd_sel, output rd_data, rd_valid);
endinterface

// File: rtl/cpu_stat_unit_stat_counter.sv
// Single event counter with synchronous clear, wrap or saturate behaviour,
// and a one-cycle overflow pulse (wrap, or first arrival at all-ones).
module stat_counter #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == ALL_ONES) begin
                if (SATURATE == 0) begin
                    cnt_d = '0;
                    ovf_o = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if ((SATURATE != 0) && (cnt_d == ALL_ONES)) begin
                    ovf_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_stat_unit.sv
// Retired-instruction statistics: NUM_CH live counters, shadow snapshot, 1-cycle readout.
// Optional overflow flags/interrupt enabled by defining CPU_STAT_OVF_IRQ_EN.
module cpu_stat_unit
    import cpu_stat_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int NUM_CH   = 10,
    parameter int SATURATE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       retire,
    input  logic       halt,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_rd,
    input  logic       mem_wr,
    input  logic       br_taken,
    input  logic       exc,
    input  logic       clr,
    input  logic       snap,
    cpu_stat_unit_if.slave rd_bus
`ifdef CPU_STAT_OVF_IRQ_EN
    ,
    output logic              ovf_irq,
    output logic [NUM_CH-1:0] ovf_flags
`endif
);
    cpu_ev_t                      ev_in;
    logic [NUM_CH_MAX-1:0]        ev;
    logic [NUM_CH-1:0][CNT_W-1:0] live;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0]             rd_data_q, rd_data_d;
    logic                         rd_valid_q;
`ifdef CPU_STAT_OVF_IRQ_EN
    logic [NUM_CH-1:0]            ovf_pulse;
    logic [NUM_CH-1:0]            flags_q, flags_d;
    logic                         irq_q;
`else
    logic [NUM_CH-1:0]            ovf_unused;
`endif

    assign ev_in = {retire, halt, op, funct, mem_rd, mem_wr, br_taken, exc};
    assign ev    = classify(ev_in);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stat_counter #(
            .CNT_W   (CNT_W),
            .SATURATE(SATURATE)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (ev[i]),
            .clr  (clr),
            .cnt_o(live[i]),
`ifdef CPU_STAT_OVF_IRQ_EN
            .ovf_o(ovf_pulse[i])
`else
            .ovf_o(ovf_unused[i])
`endif
        );
    end

    // Channels beyond NUM_CH (and selects above 9) read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_bus.rd_sel == 4'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    // Shadow is read before it is rewritten, so snap+rd_req returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (snap) begin
                shadow_q <= live;
            end
            rd_valid_q <= rd_bus.rd_req;
            if (rd_bus.rd_req) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_bus.rd_data  = rd_data_q;
    assign rd_bus.rd_valid = rd_valid_q;

`ifdef CPU_STAT_OVF_IRQ_EN
    assign flags_d = clr ? '0 : (flags_q | ovf_pulse);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            irq_q   <= |flags_d;
        end
    end

    assign ovf_flags = flags_q;
    assign ovf_irq   = irq_q;
`endif

endmodule

// File: tb/tb_cpu_stat_unit.sv
// Bench for cpu_stat_unit: a wrap-mode 10-channel and a saturate-mode 8-channel instance
// driven in lockstep and compared against an arithmetic reference model.
module tb_cpu_stat_unit;
    localparam int CW   = 8;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, retire, halt, mem_rd, mem_wr, br_taken, exc, clr, snap, rd_req;
    logic [5:0] op, funct;
    logic [3:0] rd_sel;

    cpu_stat_unit_if #(.CNT_W(CW)) bus_w ();
    cpu_stat_unit_if #(.CNT_W(CW)) bus_s ();
    assign bus_w.rd_req = rd_req;
    assign bus_w.rd_sel = rd_sel;
    assign bus_s.rd_req = rd_req;
    assign bus_s.rd_sel = rd_sel;

`ifdef CPU_STAT_OVF_IRQ_EN
    logic       irq_w, irq_s;
    logic [9:0] flags_w;
    logic [7:0] flags_s;
`endif

    cpu_stat_unit #(.CNT_W(CW), .NUM_CH(10), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .retire(retire), .halt(halt), .op(op), .funct(funct),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .br_taken(br_taken), .exc(exc),
        .clr(clr), .snap(snap), .rd_bus(bus_w)
`ifdef CPU_STAT_OVF_IRQ_EN
        , .ovf_irq(irq_w), .ovf_flags(flags_w)
`endif
    );

    cpu_stat_unit #(.CNT_W(CW), .NUM_CH(8), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .retire(retire), .halt(halt), .op(op), .funct(funct),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .br_taken(br_taken), .exc(exc),
        .clr(clr), .snap(snap), .rd_bus(bus_s)
`ifdef CPU_STAT_OVF_IRQ_EN
        , .ovf_irq(irq_s), .ovf_flags(flags_s)
`endif
    );

    // Reference model state, index 0 = wrap instance, 1 = saturate instance
    int unsigned mlive[2][10];
    int unsigned mshad[2][10];
    bit          mflag[2][10];
    int unsigned exp_data[2];
    bit          exp_valid;
    int          nch[2] = '{10, 8};
    bit          satm[2] = '{1'b0, 1'b1};
    int          errors = 0;
    int          checks = 0;

    function automatic bit [9:0] events();
        bit [9:0] e;
        bit       rt, jt;
        e = '0;
        if (halt) return e;
        rt   = (op == 6'h00);
        jt   = (op == 6'h02) || (op == 6'h03);
        e[0] = 1'b1;
        e[1] = retire;
        e[2] = retire && rt;
        e[3] = retire && jt;
        e[4] = retire && !rt && !jt;
        e[5] = retire && mem_rd;
        e[6] = retire && mem_wr;
        e[7] = retire && br_taken;
        e[8] = retire && rt && (funct == 6'h0C);
        e[9] = exc;
        return e;
    endfunction

    task automatic model_edge();
        bit [9:0] e;
        e = events();
        if (reset) begin
            exp_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_data[d] = 0;
                for (int c = 0; c < 10; c++) begin
                    mlive[d][c] = 0; mshad[d][c] = 0; mflag[d][c] = 1'b0;
                end
            end
            return;
        end
        exp_valid = rd_req;
        for (int d = 0; d < 2; d++) begin
            if (rd_req) exp_data[d] = (int'(rd_sel) < nch[d]) ? mshad[d][rd_sel] : 0;
            for (int c = 0; c < nch[d]; c++) begin
                if (snap) mshad[d][c] = mlive[d][c];
                if (clr) begin
                    mlive[d][c] = 0;
                    mflag[d][c] = 1'b0;
                end else if (e[c]) begin
                    if (satm[d]) begin
                        if (mlive[d][c] < MAXV) mlive[d][c] = mlive[d][c] + 1;
                        if (mlive[d][c] == MAXV) mflag[d][c] = 1'b1;
                    end else begin
                        mlive[d][c] = (mlive[d][c] + 1) % (MAXV + 1);
                        if (mlive[d][c] == 0) mflag[d][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("rd_valid_w", bus_w.rd_valid, exp_valid);
        check("rd_valid_s", bus_s.rd_valid, exp_valid);
        if (exp_valid) begin
            check("rd_data_w", bus_w.rd_data, exp_data[0]);
            check("rd_data_s", bus_s.rd_data, exp_data[1]);
        end
`ifdef CPU_STAT_OVF_IRQ_EN
        begin
            bit any_w, any_s;
            any_w = 1'b0; any_s = 1'b0;
            for (int c = 0; c < 10; c++) begin
                check("ovf_flag_w", flags_w[c], mflag[0][c]);
                any_w |= mflag[0][c];
            end
            for (int c = 0; c < 8; c++) begin
                check("ovf_flag_s", flags_s[c], mflag[1][c]);
                any_s |= mflag[1][c];
            end
            check("ovf_irq_w", irq_w, any_w);
            check("ovf_irq_s", irq_s, any_s);
        end
`endif
    endtask

    task automatic idle();
        retire = 0; halt = 0; op = '0; funct = '0; mem_rd = 0; mem_wr = 0;
        br_taken = 0; exc = 0; clr = 0; snap = 0; rd_req = 0; rd_sel = '0;
    endtask

    task automatic read_ch(input int sel, input int ew, input int es, input string nm);
        rd_req = 1'b1; rd_sel = 4'(sel);
        step();
        check({nm, "_valid"}, bus_w.rd_valid, 1);
        check({nm, "_w"}, bus_w.rd_data, 64'(ew));
        check({nm, "_s"}, bus_s.rd_data, 64'(es));
        rd_req = 1'b0;
    endtask

    task automatic do_snap();
        idle(); snap = 1'b1; step(); snap = 1'b0;
    endtask

    typedef struct {
        logic       retire, halt;
        logic [5:0] op, funct;
        logic       mem_rd, mem_wr, br, exc;
        logic [9:0] mask;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 6'h00, 6'h20, 0, 0, 0, 0, 10'b0000000111};
        tbl[1] = '{1, 0, 6'h00, 6'h0C, 0, 0, 0, 0, 10'b0100000111};
        tbl[2] = '{1, 0, 6'h02, 6'h00, 0, 0, 1, 0, 10'b0010001011};
        tbl[3] = '{1, 0, 6'h03, 6'h11, 0, 0, 0, 0, 10'b0000001011};
        tbl[4] = '{1, 0, 6'h23, 6'h00, 1, 0, 0, 0, 10'b0000110011};
        tbl[5] = '{1, 0, 6'h2B, 6'h00, 0, 1, 0, 0, 10'b0001010011};
        tbl[6] = '{0, 0, 6'h00, 6'h0C, 0, 0, 0, 1, 10'b1000000001};
        tbl[7] = '{0, 0, 6'h23, 6'h00, 1, 1, 1, 0, 10'b0000000001};
        tbl[8] = '{1, 1, 6'h00, 6'h0C, 1, 1, 1, 1, 10'b0000000000};
        tbl[9] = '{1, 0, 6'h04, 6'h00, 0, 0, 1, 1, 10'b1010010011};

        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Five R-type retirements
        retire = 1; op = 6'h00; funct = 6'h20;
        repeat (5) step();
        do_snap();
        read_ch(2, 5, 5, "rtype_ch2");
        read_ch(1, 5, 5, "rtype_ch1");
        read_ch(0, 5, 5, "rtype_ch0");
        read_ch(3, 0, 0, "rtype_ch3");
        step();
        check("rd_valid_pulse", bus_w.rd_valid, 0);

        // Loads then taken jumps
        idle(); clr = 1; step(); clr = 0;
        retire = 1; op = 6'h23; mem_rd = 1;
        repeat (3) step();
        mem_rd = 0; op = 6'h02; br_taken = 1;
        repeat (2) step();
        do_snap();
        read_ch(4, 3, 3, "ld_ch4");
        read_ch(5, 3, 3, "ld_ch5");
        read_ch(3, 2, 2, "j_ch3");
        read_ch(7, 2, 2, "j_ch7");

        // Halt window freezes everything
        idle(); clr = 1; step(); clr = 0;
        retire = 1; op = 6'h00;
        repeat (4) step();
        halt = 1; repeat (6) step();
        halt = 0; repeat (2) step();
        do_snap();
        read_ch(0, 6, 6, "halt_ch0");
        read_ch(1, 6, 6, "halt_ch1");

        // 257 retirements: wrap vs saturate
        idle(); clr = 1; step(); clr = 0;
        retire = 1; op = 6'h00;
        repeat (257) step();
        do_snap();
`ifdef CPU_STAT_OVF_IRQ_EN
        check("ovf1_w", flags_w[1], 1);
        check("ovf1_s", flags_s[1], 1);
        check("irq_w", irq_w, 1);
        check("irq_s", irq_s, 1);
`endif
        read_ch(1, 1, 255, "wrap_ch1");

        // clr + snap + increment together
        idle(); clr = 1; snap = 1; retire = 1; step();
        idle();
        read_ch(1, 1, 255, "preclr_ch1");
        retire = 1; repeat (2) step();
        do_snap();
        read_ch(1, 2, 2, "postclr_ch1");

        // Out-of-range select, reset over a pending readout
        read_ch(12, 0, 0, "sel12");
        rd_req = 1; rd_sel = 4'd1; step();
        check("pre_reset_valid", bus_w.rd_valid, 1);
        rd_req = 0; reset = 1; step();
        check("reset_drop_valid", bus_w.rd_valid, 0);
        rd_req = 1; step();
        check("reset_vs_req", bus_s.rd_valid, 0);
        reset = 0; rd_req = 0;
        for (int c = 0; c < 10; c++) read_ch(c, 0, 0, "post_reset");

        // Classification table
        for (int t = 0; t < 10; t++) begin
            idle(); clr = 1; step(); clr = 0;
            retire = tbl[t].retire; halt = tbl[t].halt; op = tbl[t].op; funct = tbl[t].funct;
            mem_rd = tbl[t].mem_rd; mem_wr = tbl[t].mem_wr; br_taken = tbl[t].br; exc = tbl[t].exc;
            step();
            do_snap();
            for (int c = 0; c < 10; c++)
                read_ch(c, int'(tbl[t].mask[c]), (c < 8) ? int'(tbl[t].mask[c]) : 0, "tbl");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            rd_req   = 1'($urandom);
            rd_sel   = 4'($urandom);
            halt     = ($urandom_range(0, 5) == 0);
            retire   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h02;
                2: op = 6'h03;
                3: op = 6'h23;
                4: op = 6'h2B;
                5: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            funct    = ($urandom_range(0, 3) == 0) ? 6'h0C : 6'($urandom);
            mem_rd   = 1'($urandom);
            mem_wr   = 1'($urandom);
            br_taken = 1'($urandom);
            exc      = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_stat_unit.md
Name: cpu_stat_unit

Overview:
Parametrised successor to the fixed J/R/I/total-cycle statistics counters of the single-cycle CPU.
- Classifies every retired instruction into up to 10 event channels of configurable width.
- Freezes on Halt; supports wrap or saturate mode, synchronous clear, an atomic snapshot, and a request/valid readout port.
- Sits beside the CPU top, fed by the instruction word and control-unit strobes.

Parameters:
CNT_W, 32, counter width in bits (8..64)
NUM_CH, 10, implemented channels (4..10); channels >= NUM_CH read 0
SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at all-ones

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
retire  input  1  an instruction completes this cycle
halt  input  1  CPU halted (syscall exit); freezes all counting
op  input  6  instruction bits [31:26]
funct  input  6  instruction bits [5:0]
mem_rd  input  1  load executing (MemRead)
mem_wr  input  1  store executing (MemWrite)
br_taken  input  1  branch or jump redirected PC
exc  input  1  exception taken (HasExp)
clr  input  1  synchronous clear of live counters
snap  input  1  copy all live counters into shadow registers
rd_req  input  1  readout request
rd_sel  input  4  channel index for readout
rd_data  output  CNT_W  shadow value of the selected channel
rd_valid  output  1  one-cycle pulse; rd_data valid

Behaviour:
- Channel map:
  - 0: cycles (every non-halted cycle)
  - 1: retired
  - 2: R-type (op==0)
  - 3: J-type (op==2 or 3)
  - 4: I-type (retire, op not 0/2/3)
  - 5: loads (retire & mem_rd)
  - 6: stores (retire & mem_wr)
  - 7: taken branches/jumps (retire & br_taken)
  - 8: syscalls (op==0, funct==0x0C)
  - 9: exceptions (exc; does not require retire)
- Channels 2,3,4,8 require retire. Channels 2/3/4 are mutually exclusive per cycle.
- halt=1: no channel increments that cycle, including cycles. Resumes on halt deassert.
- Increment is +1 per cycle per channel.
  - Wrap mode: all-ones -> 0.
  - Saturate mode: all-ones holds.
- clr=1: all live counters <= 0 next edge. clr beats a same-cycle increment (result 0, not 1).
- snap=1: shadow[i] <= live[i] as sampled before this edge's update. With snap and clr together, the shadow gets pre-clear values.
- Readout:
  - rd_req at edge N: rd_valid=1 and rd_data=shadow[rd_sel] during cycle N+1. Latency is exactly 1.
  - Back-to-back requests are allowed, one per cycle, with no stall.
  - rd_sel >= NUM_CH or >9 returns 0 with rd_valid still asserted.
  - snap and rd_req in the same cycle return the old shadow value.
- Reset:
  - All live counters, shadows, rd_data and rd_valid are 0.
  - Reset dominates clr, snap and rd_req.
  - Reset mid-readout drops the pending rd_valid.
- Inputs are sampled only on clk. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: CPU_STAT_OVF_IRQ_EN.
- Defined:
  - Adds output ovf_irq (1) and output ovf_flags (NUM_CH).
  - Flag i is set sticky when channel i wraps (wrap mode) or first reaches all-ones (saturate mode).
  - ovf_irq = OR of flags, registered.
  - Flags clear on reset or clr.
- Undefined: no extra ports or logic. Overflow is silent.

Decomposition:
- Package cpu_stat_pkg holds:
  - Channel index constants CH_CYCLES..CH_EXC (0..9) and NUM_CH_MAX=10.
  - Opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03, FN_SYSCALL=6'h0C.
- One natural sub-module: stat_counter. It is one CNT_W counter with inc, clr, SATURATE and overflow-pulse output, instantiated NUM_CH times via generate.
- Classification decode and the readout mux live in the top.

Test Plan:
- Reset, then 5 cycles of retire with op=0x00 funct=0x20 -> rd ch2=5, ch1=5, ch0=5, ch3=0 after snap, with rd_valid exactly 1 cycle after rd_req.
- Retire op=0x23 with mem_rd for 3 cycles, then op=0x02 with br_taken for 2 cycles -> ch4=3, ch5=3, ch3=2, ch7=2.
- Run 4 cycles, assert halt 6 cycles, run 2 cycles, snap -> ch0=6; counts are unchanged across the halt window.
- CNT_W=8: 257 retires -> ch1=1 with SATURATE=0; ch1=255 with SATURATE=1. With CPU_STAT_OVF_IRQ_EN, ovf_flags[1]=1 and ovf_irq=1.
- clr, snap and an increment in the same cycle -> shadow holds pre-clear value, live=0; a following snap reads 0 plus any later increments.
- rd_sel=12 with rd_req -> rd_data=0, rd_valid=1. Assert reset during the cycle after rd_req -> rd_valid=0 and all reads return 0.
